// File: rtl/sine_seq_ctrl.sv
// Start/stop sequencer that walks the sine width ROM at a programmable phase step
// and delivers each ROM word to the PWM width register with a one-cycle valid pulse.
module sine_seq_ctrl #(
  parameter int unsigned DIV_MAX = 1000,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] step,
  input  logic [7:0]        n_periods,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] width_out,
  output logic              width_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DIV_W = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  phase;
  logic [ADDR_W-1:0]  step_q;
  logic [7:0]         n_q;
  logic [7:0]         pcnt;
  logic [DIV_W-1:0]   div;
  logic [ROM_LAT-1:0] vpipe;

  logic [ADDR_W:0]    sum;
  logic               carry;
  logic [7:0]         pcnt_inc;
  logic               last;

  // A stop arriving in a read slot must cancel that very read, so the enable is
  // decoded from registered state and gated by the live stop input.
  assign rom_en   = (state == RUN) && (div == '0) && !stop;
  assign rom_addr = phase;

  // Phase accumulator carry marks one completed sine period.
  assign sum      = {1'b0, phase} + {1'b0, step_q};
  assign carry    = sum[ADDR_W];
  assign pcnt_inc = (carry && (pcnt != 8'hFF)) ? pcnt + 8'd1 : pcnt;
  assign last     = carry && (n_q != 8'd0) && (pcnt_inc == n_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      phase       <= '0;
      step_q      <= '0;
      n_q         <= '0;
      pcnt        <= '0;
      div         <= '0;
      vpipe       <= '0;
      width_out   <= '0;
      width_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      width_valid <= 1'b0;
      done        <= 1'b0;

      // Latency pipe follows each issued read until its data is captured.
      vpipe <= ROM_LAT'({vpipe, rom_en});
      if (vpipe[ROM_LAT-1]) begin
        width_out   <= rom_data;
        width_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start && !stop) begin
            step_q <= (step == '0) ? ADDR_W'(1) : step;
            n_q    <= n_periods;
            phase  <= '0;
            div    <= '0;
            pcnt   <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state <= DRAIN;
          end else begin
            div <= (div == DIV_W'(DIV_MAX - 1)) ? '0 : div + DIV_W'(1);
            if (div == '0) begin
              phase <= sum[ADDR_W-1:0];
              pcnt  <= pcnt_inc;
              if (last) state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Empty pipe means the final width_valid is firing now or already has.
          if (vpipe == '0) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            width_out <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sine_seq_ctrl.sv
// Directed bench for sine_seq_ctrl with a registered ROM model and a
// closed-form read schedule for each sequence.
module tb_sine_seq_ctrl;

  localparam int unsigned DIV = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [5:0]  step;
  logic [7:0]  n_periods;
  logic        rom_en;
  logic [5:0]  rom_addr;
  logic [31:0] rom_data;
  logic [31:0] width_out;
  logic        width_valid;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int cur_t = 0;

  sine_seq_ctrl #(.DIV_MAX(DIV), .ADDR_W(6), .DATA_W(32), .ROM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step),
    .n_periods(n_periods), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .width_out(width_out), .width_valid(width_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [5:0] a);
    return 32'h00A5_0000 + 32'(a) * 32'd977 + 32'd3;
  endfunction

  // Registered ROM, one cycle of latency.
  always_ff @(posedge clk) begin
    if (rom_en) rom_data <= word(rom_addr);
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0d", cur_t);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, cur_t, obs, exp);
    end
  endtask

  function automatic bit issued(input int j, input int nreads, input bit stop_eff,
                                input int stop_t);
    return ((nreads == 0) || (j < nreads)) && (!stop_eff || (8 * j + 1 < stop_t));
  endfunction

  // Start a sequence, then check every cycle against the schedule:
  // read j in cycle 8j+1, its width_valid in 8j+3, done one cycle after DRAIN empties.
  task automatic run_seq(input logic [5:0] st, input logic [7:0] np, input int stop_t,
                         input int xstart_t, input int chg_t, input int tmax);
    int  step_e, nreads, lst, drain, done_t, jj;
    bit  stop_eff, exp_en, exp_vld;
    logic [31:0] exp_w;
    step_e   = (st == 6'd0) ? 1 : int'(st);
    nreads   = (np == 8'd0) ? 0 : (int'(np) * 64 + step_e - 1) / step_e;
    stop_eff = (stop_t > 0) && ((nreads == 0) || (stop_t <= 8 * (nreads - 1) + 1));
    lst      = (nreads == 0) ? 1 << 20 : nreads - 1;
    if (stop_eff && ((stop_t - 2) / 8 < lst)) lst = (stop_t - 2) / 8;
    if (!stop_eff && nreads == 0) done_t = 1 << 30;
    else begin
      drain  = stop_eff ? stop_t + 1 : 8 * lst + 2;
      done_t = ((drain > 8 * lst + 3) ? drain : 8 * lst + 3) + 1;
    end
    tick();
    start = 1'b1; stop = 1'b0; step = st; n_periods = np;
    for (int t = 1; t <= tmax && t <= done_t + 1; t++) begin
      tick();
      cur_t = t;
      start = (t == xstart_t);
      stop  = (t == stop_t);
      if (t == chg_t) begin step = 6'd9; n_periods = 8'd3; end
      #1;
      exp_en  = ((t - 1) % 8 == 0) && issued((t - 1) / 8, nreads, stop_eff, stop_t);
      exp_vld = (t >= 3) && ((t - 3) % 8 == 0) && issued((t - 3) / 8, nreads, stop_eff, stop_t);
      exp_w   = 32'd0;
      if (t < done_t && t >= 3) begin
        jj = (t - 3) / 8;
        if (jj > lst) jj = lst;
        exp_w = word(6'((jj * step_e) % 64));
      end
      chk("rom_en", 32'(rom_en), 32'(exp_en));
      if (exp_en) chk("rom_addr", 32'(rom_addr), 32'(((t - 1) / 8 * step_e) % 64));
      chk("width_valid", 32'(width_valid), 32'(exp_vld));
      chk("width_out", width_out, exp_w);
      chk("done", 32'(done), 32'(t == done_t));
      chk("busy", 32'(busy), 32'(t < done_t));
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rom_en"}, 32'(rom_en), 32'd0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, "_width_out"}, width_out, 32'd0);
    chk({tag, "_width_valid"}, 32'(width_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; step = 6'd1; n_periods = 8'd0;
    repeat (3) tick();
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Continuous step 1 across the address wrap, stray start mid-run, stop 3 cycles after read 65.
    run_seq(6'd1, 8'd0, 8 * 65 + 1 + 3, 20, 0, 700);

    // start together with stop in IDLE stays idle.
    tick();
    start = 1'b1; stop = 1'b1; step = 6'd3; n_periods = 8'd1;
    tick();
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      cur_t = i;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_rom_en", 32'(rom_en), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end

    // One period at step 4: 16 reads then done.
    run_seq(6'd4, 8'd1, 0, 0, 0, 300);

    // Step 0 acts as step 1; step/n_periods change mid-run is ignored.
    run_seq(6'd0, 8'd1, 0, 0, 100, 700);

    // Stop landing exactly on a read slot suppresses that read.
    run_seq(6'd2, 8'd0, 17, 0, 0, 100);

    // Reset one cycle after a read: pending data dropped, no done.
    run_seq(6'd1, 8'd0, 0, 0, 0, 18);
    rst_n = 1'b0;
    tick();
    cur_t = 19;
    #1;
    chk_all_zero("midrst");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      cur_t = 20 + i;
      chk("postrst_valid", 32'(width_valid), 32'd0);
      chk("postrst_done", 32'(done), 32'd0);
    end

    // Normal sequence after the abort.
    run_seq(6'd4, 8'd1, 0, 0, 0, 300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
